// File: rtl/control_unit.sv
// Hardwired control sequencer: a three-step fetch followed by up to five opcode-specific
// execute steps. It drives the bus-source strobes, load strobes, memory strobes and ALU-op strobes.
module control_unit (
  input  logic        clk,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        Stop,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        Cout,
  output logic        BAout,
  output logic        Rout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Rin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        ADD,
  output logic        SUB,
  output logic        AND,
  output logic        OR,
  output logic        Run
);

  typedef enum logic [3:0] {
    RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALT
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t     state_reg;
  logic       stop_pending_reg;
  logic [4:0] opcode;
  logic       is_ld, is_ldi, is_st, is_addi, is_rtype, is_mem, is_exec;
  logic       last_step;
  state_t     end_state;

  // IR is only trusted from T3 onward, once IRin has loaded it during T2.
  assign opcode   = IR[31:27];
  assign is_ld    = (opcode == OP_LD);
  assign is_ldi   = (opcode == OP_LDI);
  assign is_st    = (opcode == OP_ST);
  assign is_addi  = (opcode == OP_ADDI);
  assign is_rtype = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                    (opcode == OP_AND) || (opcode == OP_OR);
  assign is_mem   = is_ld || is_ldi || is_st;
  assign is_exec  = is_mem || is_rtype || is_addi;

  assign last_step = (state_reg == T7) ||
                     (state_reg == T5 && (is_ldi || is_rtype || is_addi)) ||
                     (state_reg == T3 && !is_exec);

  // A Stop seen at any point in an instruction is held until the next boundary.
  assign end_state = (Stop || stop_pending_reg) ? HALT : T0;

  always_ff @(posedge clk) begin
    if (clear) begin
      state_reg        <= RESET;
      stop_pending_reg <= 1'b0;
    end else begin
      case (state_reg)
        RESET:   state_reg <= T0;
        T0:      state_reg <= T1;
        T1:      state_reg <= T2;
        T2:      state_reg <= T3;
        T3:      state_reg <= (opcode == OP_HALT) ? HALT : (is_exec ? T4 : end_state);
        T4:      state_reg <= T5;
        T5:      state_reg <= (is_ld || is_st) ? T6 : end_state;
        T6:      state_reg <= T7;
        T7:      state_reg <= end_state;
        default: state_reg <= HALT;
      endcase
      stop_pending_reg <= last_step ? 1'b0 : (stop_pending_reg || Stop);
    end
  end

  always_comb begin
    {PCout, Zlowout, MDRout, Cout, BAout, Rout} = '0;
    {MARin, Zin, PCin, MDRin, IRin, Yin, Rin}   = '0;
    {Gra, Grb, Grc}                             = '0;
    {IncPC, Read, Write, ADD, SUB, AND, OR}     = '0;
    Run = (state_reg != RESET) && (state_reg != HALT);
    case (state_reg)
      T0: {PCout, MARin, IncPC, Zin} = '1;
      T1: {Zlowout, PCin, Read, MDRin} = '1;
      T2: {MDRout, IRin} = '1;
      T3: begin
        if (is_mem) {Grb, BAout, Yin} = '1;
        else if (is_rtype || is_addi) {Grb, Rout, Yin} = '1;
      end
      T4: begin
        if (is_mem || is_addi) {Cout, ADD, Zin} = '1;
        else if (is_rtype) begin
          {Grc, Rout, Zin} = '1;
          ADD = (opcode == OP_ADD);
          SUB = (opcode == OP_SUB);
          AND = (opcode == OP_AND);
          OR  = (opcode == OP_OR);
        end
      end
      T5: begin
        if (is_ld || is_st) {Zlowout, MARin} = '1;
        else if (is_ldi || is_rtype || is_addi) {Zlowout, Gra, Rin} = '1;
      end
      T6: begin
        if (is_ld) {Read, MDRin} = '1;
        else if (is_st) {Gra, Rout, MDRin} = '1;
      end
      T7: begin
        if (is_ld) {MDRout, Gra, Rin} = '1;
        else if (is_st) Write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: the driver queues the expected strobe vector for each cycle,
// and a monitor compares it against the DUT outputs half a cycle later.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] IR = '0;
  logic        Stop = 1'b0;
  logic PCout, Zlowout, MDRout, Cout, BAout, Rout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, Rin;
  logic Gra, Grb, Grc, IncPC, Read, Write, ADD, SUB, AND, OR, Run;

  control_unit dut (
    .clk(clk), .clear(clear), .IR(IR), .Stop(Stop),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout), .BAout(BAout), .Rout(Rout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Rin(Rin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .Read(Read), .Write(Write),
    .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .Run(Run)
  );

  always #5 clk = ~clk;

  localparam logic [23:0] B_OR      = 24'd1 << 0;
  localparam logic [23:0] B_AND     = 24'd1 << 1;
  localparam logic [23:0] B_SUB     = 24'd1 << 2;
  localparam logic [23:0] B_ADD     = 24'd1 << 3;
  localparam logic [23:0] B_WRITE   = 24'd1 << 4;
  localparam logic [23:0] B_READ    = 24'd1 << 5;
  localparam logic [23:0] B_INCPC   = 24'd1 << 6;
  localparam logic [23:0] B_GRC     = 24'd1 << 7;
  localparam logic [23:0] B_GRB     = 24'd1 << 8;
  localparam logic [23:0] B_GRA     = 24'd1 << 9;
  localparam logic [23:0] B_RIN     = 24'd1 << 10;
  localparam logic [23:0] B_YIN     = 24'd1 << 11;
  localparam logic [23:0] B_IRIN    = 24'd1 << 12;
  localparam logic [23:0] B_MDRIN   = 24'd1 << 13;
  localparam logic [23:0] B_PCIN    = 24'd1 << 14;
  localparam logic [23:0] B_ZIN     = 24'd1 << 15;
  localparam logic [23:0] B_MARIN   = 24'd1 << 16;
  localparam logic [23:0] B_ROUT    = 24'd1 << 17;
  localparam logic [23:0] B_BAOUT   = 24'd1 << 18;
  localparam logic [23:0] B_COUT    = 24'd1 << 19;
  localparam logic [23:0] B_MDROUT  = 24'd1 << 20;
  localparam logic [23:0] B_ZLOWOUT = 24'd1 << 21;
  localparam logic [23:0] B_PCOUT   = 24'd1 << 22;
  localparam logic [23:0] B_RUN     = 24'd1 << 23;

  localparam logic [23:0] F0 = B_RUN | B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
  localparam logic [23:0] F1 = B_RUN | B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN;
  localparam logic [23:0] F2 = B_RUN | B_MDROUT | B_IRIN;
  localparam logic [23:0] MEM3 = B_RUN | B_GRB | B_BAOUT | B_YIN;
  localparam logic [23:0] IMM4 = B_RUN | B_COUT | B_ADD | B_ZIN;
  localparam logic [23:0] ADR5 = B_RUN | B_ZLOWOUT | B_MARIN;
  localparam logic [23:0] R3   = B_RUN | B_GRB | B_ROUT | B_YIN;
  localparam logic [23:0] R4   = B_RUN | B_GRC | B_ROUT | B_ZIN;
  localparam logic [23:0] WB5  = B_RUN | B_ZLOWOUT | B_GRA | B_RIN;

  localparam logic [31:0] I_LD   = 32'h0080_0055;
  localparam logic [31:0] I_ST   = 32'h1080_0090;
  localparam logic [31:0] I_ADD  = 32'h1989_0000;
  localparam logic [31:0] I_SUB  = 32'h2000_0000;
  localparam logic [31:0] I_AND  = 32'h2800_0000;
  localparam logic [31:0] I_OR   = 32'h3000_0000;
  localparam logic [31:0] I_ADDI = 32'h6000_0000;
  localparam logic [31:0] I_LDI  = 32'h0800_0000;
  localparam logic [31:0] I_NOP  = 32'h3800_0000;
  localparam logic [31:0] I_HALT = 32'hD800_0000;

  logic [23:0] act;
  assign act = {Run, PCout, Zlowout, MDRout, Cout, BAout, Rout, MARin, Zin, PCin, MDRin,
                IRin, Yin, Rin, Gra, Grb, Grc, IncPC, Read, Write, ADD, SUB, AND, OR};

  logic [23:0] exp_q[$];
  int compared = 0;
  int mismatched = 0;
  int cycle = 0;
  bit done = 1'b0;

  // One expected vector per cycle; the inputs applied here take effect at the next rising edge.
  task automatic cyc(input logic [31:0] ir, input logic stop, input logic clr, input logic [23:0] e);
    @(negedge clk);
    IR = ir;
    Stop = stop;
    clear = clr;
    exp_q.push_back(e);
  endtask

  task automatic fetch(input logic [31:0] ir);
    cyc(ir, 1'b0, 1'b0, F0);
    cyc(ir, 1'b0, 1'b0, F1);
    cyc(ir, 1'b0, 1'b0, F2);
  endtask

  task automatic rtype(input logic [31:0] ir, input logic [23:0] op);
    fetch(ir);
    cyc(ir, 1'b0, 1'b0, R3);
    cyc(ir, 1'b0, 1'b0, R4 | op);
    cyc(ir, 1'b0, 1'b0, WB5);
  endtask

  // Monitor: compare whatever was queued for this cycle once the outputs have settled.
  always @(negedge clk) begin
    #2;
    cycle++;
    if (exp_q.size() > 0) begin
      automatic logic [23:0] e = exp_q.pop_front();
      compared++;
      if (act !== e) begin
        mismatched++;
        $display("FAIL outputs cycle %0d: got %06h want %06h", cycle, act, e);
      end else
        $display("ok cycle %0d outputs %06h", cycle, act);
    end
  end

  logic [5:0] bus;
  assign bus = {PCout, Zlowout, MDRout, Cout, BAout, Rout};
  always @(negedge clk) begin
    #1;
    assert ($onehot0(bus) && !(Read && Write))
      else $error("bus contention or Read with Write at %0t", $time);
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    cyc(I_LD, 1'b0, 1'b1, 24'h0);
    cyc(I_LD, 1'b0, 1'b0, 24'h0);
    // ld R1,$55(R0)
    fetch(I_LD);
    cyc(I_LD, 1'b0, 1'b0, MEM3);
    cyc(I_LD, 1'b0, 1'b0, IMM4);
    cyc(I_LD, 1'b0, 1'b0, ADR5);
    cyc(I_LD, 1'b0, 1'b0, B_RUN | B_READ | B_MDRIN);
    cyc(I_LD, 1'b0, 1'b0, B_RUN | B_MDROUT | B_GRA | B_RIN);
    // st $90,R1
    fetch(I_ST);
    cyc(I_ST, 1'b0, 1'b0, MEM3);
    cyc(I_ST, 1'b0, 1'b0, IMM4);
    cyc(I_ST, 1'b0, 1'b0, ADR5);
    cyc(I_ST, 1'b0, 1'b0, B_RUN | B_GRA | B_ROUT | B_MDRIN);
    cyc(I_ST, 1'b0, 1'b0, B_RUN | B_WRITE);
    rtype(I_ADD, B_ADD);
    rtype(I_SUB, B_SUB);
    rtype(I_AND, B_AND);
    rtype(I_OR, B_OR);
    // ldi
    fetch(I_LDI);
    cyc(I_LDI, 1'b0, 1'b0, MEM3);
    cyc(I_LDI, 1'b0, 1'b0, IMM4);
    cyc(I_LDI, 1'b0, 1'b0, WB5);
    // nop
    fetch(I_NOP);
    cyc(I_NOP, 1'b0, 1'b0, B_RUN);
    // addi with a Stop pulse in T4 ends in HALT after T5
    fetch(I_ADDI);
    cyc(I_ADDI, 1'b0, 1'b0, R3);
    cyc(I_ADDI, 1'b1, 1'b0, IMM4);
    cyc(I_ADDI, 1'b0, 1'b0, WB5);
    for (int i = 0; i < 3; i++) cyc(I_ADDI, 1'b0, 1'b0, 24'h0);
    cyc(I_HALT, 1'b0, 1'b1, 24'h0);
    cyc(I_HALT, 1'b0, 1'b0, 24'h0);
    // halt instruction, then 20 idle cycles and a clear pulse
    fetch(I_HALT);
    cyc(I_HALT, 1'b0, 1'b0, B_RUN);
    for (int i = 0; i < 20; i++) cyc(I_HALT, 1'b0, 1'b0, 24'h0);
    cyc(I_LD, 1'b0, 1'b1, 24'h0);
    cyc(I_LD, 1'b0, 1'b0, 24'h0);
    // ld interrupted by clear during T6
    fetch(I_LD);
    cyc(I_LD, 1'b0, 1'b0, MEM3);
    cyc(I_LD, 1'b0, 1'b0, IMM4);
    cyc(I_LD, 1'b0, 1'b0, ADR5);
    cyc(I_LD, 1'b0, 1'b1, B_RUN | B_READ | B_MDRIN);
    cyc(I_ADD, 1'b0, 1'b0, 24'h0);
    rtype(I_ADD, B_ADD);
    cyc(I_ADD, 1'b0, 1'b0, F0);
    done = 1'b1;
  end

  initial begin
    wait (done);
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    if (exp_q.size() > 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 clear  input  1  synchronous active-high reset, same net as Datapath clear.
REQ-004 IR  input  32  instruction register from Datapath: [31:27] opcode, [26:23] Ra, [22:19] Rb, [18:15] Rc, [18:0] C.
REQ-005 Stop  input  1  request to halt at the next instruction boundary.
REQ-006 PCout, Zlowout, MDRout, Cout, BAout, Rout  output  1 each  bus-source strobes to Datapath.
REQ-007 MARin, Zin, PCin, MDRin, IRin, Yin, Rin  output  1 each  register-load strobes.
REQ-008 Gra, Grb, Grc  output  1 each  register-field select to the Datapath select/encode logic.
REQ-009 IncPC, Read, Write, ADD, SUB, AND, OR  output  1 each  PC-increment, memory and ALU-op strobes.
REQ-010 Run  output  1  high while executing; low in RESET and HALT.

Function
REQ-011 The state register SHALL hold one of RESET, T0..T7, HALT; all outputs SHALL be decoded from state and IR[31:27] only, with every output not listed for a state at 0.
REQ-012 Fetch: T0 SHALL assert PCout, MARin, IncPC, Zin; T1 Zlowout, PCin, Read, MDRin; T2 MDRout, IRin; the next states are T1, T2, T3 respectively.
REQ-013 Opcodes SHALL be: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, addi 01100, halt 11011; every other opcode is a nop.
REQ-014 ld SHALL run T3 Grb,BAout,Yin; T4 Cout,ADD,Zin; T5 Zlowout,MARin; T6 Read,MDRin; T7 MDRout,Gra,Rin.
REQ-015 ldi SHALL run T3 Grb,BAout,Yin; T4 Cout,ADD,Zin; T5 Zlowout,Gra,Rin.
REQ-016 st SHALL run T3-T5 as ld; T6 Gra,Rout,MDRin (Read=0); T7 Write.
REQ-017 add/sub/and/or SHALL run T3 Grb,Rout,Yin; T4 Grc,Rout,Zin plus exactly one of ADD/SUB/AND/OR; T5 Zlowout,Gra,Rin.
REQ-018 addi SHALL run T3 Grb,Rout,Yin; T4 Cout,ADD,Zin; T5 Zlowout,Gra,Rin.
REQ-019 nop SHALL assert nothing in T3 and end there; halt SHALL assert nothing in T3 and go to HALT.
REQ-020 Cycle counts per instruction, fetch included: ld 8, st 8, ldi 6, R-type 6, addi 6, nop 4, halt 4.
REQ-021 At the last step of every instruction, the next state SHALL be HALT if Stop=1, else T0.
REQ-022 HALT SHALL hold all strobes at 0 and Run at 0 until clear.
REQ-023 At most one bus-source strobe SHALL be high in any state; Read and Write SHALL never be high together.
REQ-024 IR SHALL be sampled only in T3..T7, and its value after T2 SHALL be treated as stable.

Reset
REQ-025 clear=1 at a rising edge SHALL force RESET from any state, including mid-instruction; no Write or Rin SHALL occur in the following cycle.
REQ-026 In RESET all outputs SHALL be 0; the first edge with clear=0 SHALL move to T0, and Run SHALL be 1 from T0 onward.
REQ-027 clear SHALL take priority over Stop and all other transitions.

Verification
REQ-028 Release clear, then IR=0x00800055 (ld R1,$55(R0)) after T2 -> T3..T7 strobes as REQ-014; Rin+Gra in cycle 8; back to T0 in cycle 9.
REQ-029 IR=0x10800090 (st $90,R1) -> Write high only in T7; MDRin with Read=0 in T6; no Rin in any step.
REQ-030 IR=0x19890000 (add R3,R1,R2) -> ADD+Grc+Rout+Zin in T4; Gra+Rin in T5; next state T0; 6 cycles total.
REQ-031 IR=0xD8000000 (halt) -> HALT after T3; Run=0; every strobe 0 for 20 cycles; clear pulse then returns to T0.
REQ-032 Stop=1 during an addi T4; clear=1 during an ld T6 -> addi ends in HALT after T5; in the ld case, RESET next cycle with Write=0 and Rin=0.
REQ-033 All scenarios: an assertion checks REQ-023 on every cycle.
